conv_kxk_mac_pipe: RTL and testbench

//  Pipelined, parametrised KxK convolution MAC. Each accepted beat carries one KxK window and its KxK weights.
//  The block accumulates CIN consecutive beats (one per input channel) into one output pixel.
//  On the last beat it adds a bias, rounds, shifts, applies optional ReLU and saturates to OUT_WIDTH.

---
 rtl/conv_kxk_mac_pipe_pkg.sv | 44 ++++
 rtl/conv_kxk_mac_pipe_requant.sv | 38 +++
 rtl/conv_kxk_mac_pipe.sv | 238 +++++++++++++++++++++++
 tb/tb_conv_kxk_mac_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_kxk_mac_pipe_pkg.sv
// conv_pkg: shared types and helpers for the KxK convolution MAC and the
// layers that reuse its requantiser.
//   DEF_*        default configuration of the conv layer
//   PROD_W/SUM_W/CNT_W  derived widths for the default configuration
//   calc_*       same derivations for arbitrary parameter sets
//   window_t     packed KxK window/weight vector (default configuration)
//   sat_signed   clamp a signed value to a signed range of 'width' bits
package conv_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_K          = 3;
  localparam int unsigned DEF_CIN        = 4;
  localparam int unsigned DEF_ACC_WIDTH  = 32;
  localparam int unsigned DEF_OUT_WIDTH  = 8;

  localparam int unsigned PROD_W = 2 * DEF_DATA_WIDTH;
  localparam int unsigned SUM_W  = PROD_W + $clog2(DEF_K * DEF_K);
  localparam int unsigned CNT_W  = (DEF_CIN > 1) ? $clog2(DEF_CIN) : 1;

  typedef logic [DEF_K*DEF_K*DEF_DATA_WIDTH-1:0] window_t;

  function automatic int unsigned calc_sum_w(input int unsigned dw, input int unsigned k);
    return 2 * dw + $clog2(k * k);
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned cin);
    return (cin > 1) ? $clog2(cin) : 1;
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/conv_kxk_mac_pipe_requant.sv
// conv_requant: combinational requantiser (bias add, round-half-up shift,
// optional ReLU, signed saturation). The caller registers the outputs.
//   acc      in   ACC_WIDTH  signed accumulator
//   bias     in   ACC_WIDTH  signed bias
//   shift    in   5          arithmetic right shift, 0 = none
//   relu_en  in   1          clamp negatives to zero
//   sum      out  ACC_WIDTH  acc + bias, wraps at ACC_WIDTH, before shift
//   q        out  OUT_WIDTH  requantised, saturated result
module conv_requant
  import conv_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned OUT_WIDTH = 8
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic signed [ACC_WIDTH-1:0] bias,
  input  logic        [4:0]           shift,
  input  logic                        relu_en,
  output logic signed [ACC_WIDTH-1:0] sum,
  output logic signed [OUT_WIDTH-1:0] q
);

  logic signed [63:0] t;

  always_comb begin
    sum = acc + bias;
    // 64-bit working value leaves headroom for the rounding increment
    t = 64'(sum);
    if (shift != '0) begin
      t = (t + (64'sd1 <<< (shift - 5'd1))) >>> shift;
    end
    if (relu_en && (t < 0)) begin
      t = '0;
    end
    q = OUT_WIDTH'(sat_signed(t, OUT_WIDTH));
  end

endmodule

// File: rtl/conv_kxk_mac_pipe.sv
// conv_kxk_mac_pipe: 4-stage pipelined KxK convolution MAC. Accumulates CIN
// beats (one per input channel) into one output pixel, then requantises.
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake; in_ready = !out_valid || out_ready
//   data_in/weight_in      KxK window and weights, element i at [i*DW +: DW]
//   bias/shift/relu_en     group parameters, taken with the first beat
//   out_valid/out_ready    output handshake, result held until accepted
//   out_data               requantised saturated result
//   out_acc                acc + bias before rounding/shift
//   busy                   partial group or any stage occupied
module conv_kxk_mac_pipe
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned K          = 3,
  parameter int unsigned CIN        = 4,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic        [K*K*DATA_WIDTH-1:0] data_in,
  input  logic        [K*K*DATA_WIDTH-1:0] weight_in,
  input  logic signed [ACC_WIDTH-1:0]      bias,
  input  logic        [4:0]                shift,
  input  logic                             relu_en,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [OUT_WIDTH-1:0]      out_data,
  output logic signed [ACC_WIDTH-1:0]      out_acc,
  output logic                             busy
);

  localparam int unsigned NTAP      = K * K;
  localparam int unsigned PROD_BITS = 2 * DATA_WIDTH;
  localparam int unsigned SUM_BITS  = calc_sum_w(DATA_WIDTH, K);
  localparam int unsigned CNT_BITS  = calc_cnt_w(CIN);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(CIN - 1);

  if (ACC_WIDTH < PROD_BITS + $clog2(NTAP * CIN)) begin : g_acc_width_check
    $error("conv_kxk_mac_pipe: ACC_WIDTH too narrow for K*K*CIN products");
  end
  if (ACC_WIDTH > 62) begin : g_acc_width_max
    $error("conv_kxk_mac_pipe: ACC_WIDTH above 62 not supported by requant");
  end

  logic en;

  // S1
  logic                        s1_valid_q, s1_valid_d;
  logic signed [PROD_BITS-1:0] s1_prod_q [NTAP];
  logic signed [PROD_BITS-1:0] s1_prod_d [NTAP];
  logic signed [PROD_BITS-1:0] prod      [NTAP];
  logic signed [ACC_WIDTH-1:0] s1_bias_q, s1_bias_d;
  logic        [4:0]           s1_shift_q, s1_shift_d;
  logic                        s1_relu_q, s1_relu_d;

  // S2
  logic                        s2_valid_q, s2_valid_d;
  logic signed [ACC_WIDTH-1:0] s2_sum_q, s2_sum_d;
  logic signed [ACC_WIDTH-1:0] s2_bias_q, s2_bias_d;
  logic        [4:0]           s2_shift_q, s2_shift_d;
  logic                        s2_relu_q, s2_relu_d;
  logic signed [SUM_BITS-1:0]  tree;

  // S3
  logic                        s3_valid_q, s3_valid_d;
  logic        [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] g_bias_q, g_bias_d;
  logic        [4:0]           g_shift_q, g_shift_d;
  logic                        g_relu_q, g_relu_d;

  // S4
  logic                        out_valid_q, out_valid_d;
  logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic signed [ACC_WIDTH-1:0] out_acc_q, out_acc_d;
  logic signed [ACC_WIDTH-1:0] rq_sum;
  logic signed [OUT_WIDTH-1:0] rq_q;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  for (genvar g = 0; g < NTAP; g++) begin : g_mul
    assign prod[g] = PROD_BITS'($signed(data_in[g*DATA_WIDTH +: DATA_WIDTH]))
                   * PROD_BITS'($signed(weight_in[g*DATA_WIDTH +: DATA_WIDTH]));
  end

  // Every beat carries the parameters live at its acceptance; S3 keeps only
  // those of the first beat, so mid-group changes never reach the result.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_prod_d  = s1_prod_q;
    s1_bias_d  = s1_bias_q;
    s1_shift_d = s1_shift_q;
    s1_relu_d  = s1_relu_q;
    if (en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_prod_d  = prod;
        s1_bias_d  = bias;
        s1_shift_d = shift;
        s1_relu_d  = relu_en;
      end
    end
  end

  always_comb begin
    tree = '0;
    for (int unsigned i = 0; i < NTAP; i++) begin
      tree = tree + SUM_BITS'(s1_prod_q[i]);
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_bias_d  = s2_bias_q;
    s2_shift_d = s2_shift_q;
    s2_relu_d  = s2_relu_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_d   = ACC_WIDTH'(tree);
        s2_bias_d  = s1_bias_q;
        s2_shift_d = s1_shift_q;
        s2_relu_d  = s1_relu_q;
      end
    end
  end

  always_comb begin
    s3_valid_d = s3_valid_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    g_bias_d   = g_bias_q;
    g_shift_d  = g_shift_q;
    g_relu_d   = g_relu_q;
    if (en) begin
      s3_valid_d = 1'b0;
      if (s2_valid_q) begin
        if (cnt_q == '0) begin
          acc_d     = s2_sum_q;
          g_bias_d  = s2_bias_q;
          g_shift_d = s2_shift_q;
          g_relu_d  = s2_relu_q;
        end else begin
          acc_d = acc_q + s2_sum_q;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d      = '0;
          s3_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
    end
  end

  conv_requant #(
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_requant (
    .acc    (acc_q),
    .bias   (g_bias_q),
    .shift  (g_shift_q),
    .relu_en(g_relu_q),
    .sum    (rq_sum),
    .q      (rq_q)
  );

  // S3 may start the next group on the same edge S4 captures this one; S4
  // samples acc/group params before they are overwritten.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_acc_d   = out_acc_q;
    if (en) begin
      out_valid_d = s3_valid_q;
      if (s3_valid_q) begin
        out_data_d = rq_q;
        out_acc_d  = rq_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '{default: '0};
      s1_bias_q   <= '0;
      s1_shift_q  <= '0;
      s1_relu_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sum_q    <= '0;
      s2_bias_q   <= '0;
      s2_shift_q  <= '0;
      s2_relu_q   <= 1'b0;
      s3_valid_q  <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      g_bias_q    <= '0;
      g_shift_q   <= '0;
      g_relu_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_acc_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_prod_q   <= s1_prod_d;
      s1_bias_q   <= s1_bias_d;
      s1_shift_q  <= s1_shift_d;
      s1_relu_q   <= s1_relu_d;
      s2_valid_q  <= s2_valid_d;
      s2_sum_q    <= s2_sum_d;
      s2_bias_q   <= s2_bias_d;
      s2_shift_q  <= s2_shift_d;
      s2_relu_q   <= s2_relu_d;
      s3_valid_q  <= s3_valid_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      g_bias_q    <= g_bias_d;
      g_shift_q   <= g_shift_d;
      g_relu_q    <= g_relu_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_acc_q   <= out_acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_acc   = out_acc_q;
  assign busy      = s1_valid_q || s2_valid_q || s3_valid_q || out_valid_q || (cnt_q != '0);

endmodule

// File: tb/tb_conv_kxk_mac_pipe.sv
// Testbench for conv_kxk_mac_pipe (DW=8, K=3, CIN=4, ACC=32, OUT=8).
// Directed cases with known results plus randomized traffic compared against
// a queue-based arithmetic reference model.
module tb_conv_kxk_mac_pipe;
  import conv_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned KK  = 3;
  localparam int unsigned NT  = KK * KK;
  localparam int unsigned CIN = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned OW  = 8;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  window_t       data_in   = '0;
  window_t       weight_in = '0;
  logic [AW-1:0] bias      = '0;
  logic [4:0]    shift     = '0;
  logic          relu_en   = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic [AW-1:0] out_acc;
  logic          busy;

  conv_kxk_mac_pipe #(
    .DATA_WIDTH(DW),
    .K         (KK),
    .CIN       (CIN),
    .ACC_WIDTH (AW),
    .OUT_WIDTH (OW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .weight_in(weight_in),
    .bias     (bias),
    .shift    (shift),
    .relu_en  (relu_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_acc  (out_acc),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int     n_chk  = 0;
  int     n_pass = 0;
  int     n_out  = 0;
  longint m_acc  = 0;
  int     m_cnt  = 0;
  longint m_bias = 0;
  int     m_shift = 0;
  bit     m_relu = 1'b0;
  longint exp_data_q[$];
  longint exp_acc_q[$];
  bit     hold_pending = 1'b0;
  longint hold_data = 0;
  longint hold_acc = 0;
  bit     last_acc = 1'b0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic window_t fill(input int v);
    window_t r;
    for (int i = 0; i < NT; i++) r[i*DW +: DW] = v[7:0];
    return r;
  endfunction

  function automatic window_t rand_win();
    window_t r;
    for (int i = 0; i < NT; i++) r[i*DW +: DW] = 8'($urandom);
    return r;
  endfunction

  function automatic longint dot(input window_t d, input window_t w);
    longint s = 0;
    for (int i = 0; i < NT; i++)
      s += longint'($signed(d[i*DW +: DW])) * longint'($signed(w[i*DW +: DW]));
    return s;
  endfunction

  task automatic push_expected();
    int     a32;
    longint t;
    a32 = int'(m_acc + m_bias);
    t   = longint'(a32);
    if (m_shift > 0) t = (t + (longint'(1) << (m_shift - 1))) >>> m_shift;
    if (m_relu && t < 0) t = 0;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    exp_data_q.push_back(t);
    exp_acc_q.push_back(longint'(a32));
  endtask

  task automatic model_beat();
    if (m_cnt == 0) begin
      m_acc   = dot(data_in, weight_in);
      m_bias  = longint'($signed(bias));
      m_shift = int'(shift);
      m_relu  = relu_en;
    end else begin
      m_acc += dot(data_in, weight_in);
    end
    m_cnt++;
    if (m_cnt == CIN) begin
      push_expected();
      m_cnt = 0;
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_acc = 0;
    exp_data_q.delete();
    exp_acc_q.delete();
    hold_pending = 1'b0;
  endtask

  // Caller sets inputs at the falling edge; this samples, updates the model
  // for the coming rising edge, and returns at the next falling edge.
  task automatic step();
    #1;
    chk("in_ready", in_ready, (!out_valid || out_ready));
    if (hold_pending) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", $signed(out_data), hold_data);
      chk("hold_acc", $signed(out_acc), hold_acc);
    end
    hold_pending = out_valid && !out_ready;
    hold_data    = $signed(out_data);
    hold_acc     = $signed(out_acc);
    if (out_valid && out_ready) begin
      chk("result_expected", exp_data_q.size() > 0, 1);
      if (exp_data_q.size() > 0) begin
        chk("out_data", $signed(out_data), exp_data_q.pop_front());
        chk("out_acc", $signed(out_acc), exp_acc_q.pop_front());
        n_out++;
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) model_beat();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_beat(input window_t d, input window_t w, input int b,
                           input int s, input bit r);
    int n = 0;
    data_in   = d;
    weight_in = w;
    bias      = b;
    shift     = s[4:0];
    relu_en   = r;
    in_valid  = 1'b1;
    do begin
      step();
      n++;
    end while (!last_acc && n < 50);
    chk("beat_accepted", last_acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    chk("out_valid_arrives", out_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_data_q.size() > 0 || out_valid || busy) && n < 60) begin
      step();
      n++;
    end
    chk("drain_busy", busy, 0);
    chk("drain_queue", exp_data_q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_acc"}, out_acc, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Four identical beats; last beat accepted on edge A, result visible after
  // edge A+3 (fourth cycle counting the acceptance cycle).
  task automatic group_const(input string tag, input window_t d, input window_t w,
                             input int b, input int s, input bit r,
                             input longint ea, input longint ed);
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < CIN; i++) send_beat(d, w, b, s, r);
    wait_out(lat);
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_acc"}, $signed(out_acc), ea);
    chk({tag, "_data"}, $signed(out_data), ed);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    window_t d4;
    window_t t5_d [8];
    window_t t5_w [8];
    int      t5_b [8];
    int      idx, stall, guard, n0;
    bit      seen;

    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    group_const("t1", fill(1), fill(2), 0, 0, 1'b0, 72, 72);
    group_const("t2_max", fill(127), fill(127), 0, 0, 1'b0, 580644, 127);
    group_const("t2_min", fill(-128), fill(127), 0, 0, 1'b0, -585216, -128);
    group_const("t2_relu", fill(-128), fill(127), 0, 0, 1'b1, -585216, 0);
    group_const("t3_pos", fill(1), fill(2), 5, 3, 1'b0, 77, 10);
    group_const("t3_neg", fill(-1), fill(2), -5, 3, 1'b0, -77, -10);
    d4 = '0;
    d4[7:0] = 8'h80;
    group_const("t4", d4, d4, 0, 0, 1'b0, 65536, 127);

    // Two back-to-back groups, output stalled 6 cycles after the first result.
    for (int i = 0; i < 8; i++) begin
      t5_d[i] = rand_win();
      t5_w[i] = rand_win();
      t5_b[i] = int'($urandom_range(0, 2000)) - 1000;
    end
    idx = 0; stall = 0; guard = 0; seen = 1'b0; n0 = n_out;
    out_ready = 1'b0;
    while ((idx < 8 || exp_data_q.size() > 0 || out_valid) && guard < 100) begin
      if (idx < 8) begin
        data_in   = t5_d[idx];
        weight_in = t5_w[idx];
        bias      = t5_b[idx];
        shift     = 5'(idx % 5);
        relu_en   = idx[0];
        in_valid  = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) seen = 1'b1;
      if (seen && stall < 6) begin
        out_ready = 1'b0;
        #1;
        chk("t5_in_ready_low", in_ready, 0);
        stall++;
      end else begin
        out_ready = seen;
      end
      step();
      if (last_acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    chk("t5_stall_cycles", stall, 6);
    chk("t5_results", n_out - n0, 2);
    drain();

    // Reset in the middle of a group discards the partial sum.
    out_ready = 1'b1;
    send_beat(fill(5), fill(7), 0, 0, 1'b0);
    send_beat(fill(5), fill(7), 0, 0, 1'b0);
    chk("t6_busy_mid", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_state("t6_in_reset");
    #1 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    n0 = n_out;
    group_const("t6", fill(1), fill(2), 0, 0, 1'b0, 72, 72);
    chk("t6_results", n_out - n0, 1);

    // Random traffic, bubbles and backpressure; group params change every beat.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      data_in   = rand_win();
      weight_in = rand_win();
      bias      = 32'(int'($urandom_range(0, 20000)) - 10000);
      shift     = 5'($urandom_range(0, 14));
      relu_en   = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    guard = 0;
    out_ready = 1'b1;
    while (m_cnt != 0 && guard < 20) begin
      in_valid  = 1'b1;
      data_in   = rand_win();
      weight_in = rand_win();
      step();
      guard++;
    end
    in_valid = 1'b0;
    chk("rand_group_closed", m_cnt, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
